xy_sequence_fsm: RTL and testbench

- Moore-style sequence detector: Z pulses one cycle when an X event is followed by a Y event within a bounded window of clock cycles.
- Sits between two single-bit event sources and a downstream consumer of a one-cycle "sequence matched" strobe.
- Single clock domain; asynchronous active-low reset.

---
 rtl/xy_sequence_fsm.sv | 74 +++++++
 tb/tb_xy_sequence_fsm.sv | 126 ++++++++++++
 2 files changed

// File: rtl/xy_sequence_fsm.sv
// Moore sequence detector: Z strobes for one cycle when a Y event follows an X
// event within WINDOW clock cycles.
module xy_sequence_fsm #(
  parameter int unsigned WINDOW = 4
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic X,
  input  logic Y,
  output logic Z
);

  localparam int unsigned CW = $clog2(WINDOW + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WINDOW - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ARMED = 2'b01,
    MATCH = 2'b10
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          z_q, z_d;

  // Y outranks X in ARMED; X restarts the window before the timeout is considered.
  always_comb begin
    state_d = IDLE;
    cnt_d   = '0;
    unique case (state_q)
      IDLE: begin
        if (X && !Y) begin
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (Y) begin
          state_d = MATCH;
        end else if (X) begin
          state_d = ARMED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          state_d = ARMED;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      MATCH: begin
        if (X && !Y) begin
          state_d = ARMED;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    z_d = (state_d == MATCH);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
    end
  end

  assign Z = z_q;

endmodule

// File: tb/tb_xy_sequence_fsm.sv
// Directed bench for xy_sequence_fsm with WINDOW=4; expected Z values are
// hand-derived from the sequence rules.
module tb_xy_sequence_fsm;

  logic CLK;
  logic RST_N;
  logic X;
  logic Y;
  logic Z;

  int checks = 0;
  int errors = 0;

  xy_sequence_fsm #(.WINDOW(4)) dut (
    .CLK  (CLK),
    .RST_N(RST_N),
    .X    (X),
    .Y    (Y),
    .Z    (Z)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Drive X/Y, let one rising edge sample them, then settle 1ns past the edge.
  task automatic apply_stimulus(input logic x, input logic y);
    X = x;
    Y = y;
    @(posedge CLK);
    #1;
  endtask

  task automatic check_output(input string tag, input logic exp);
    checks++;
    assert (Z === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: Z=%b expected %b", tag, Z, exp);
    end
  endtask

  task automatic step(input logic x, input logic y, input string tag, input logic exp);
    apply_stimulus(x, y);
    check_output(tag, exp);
  endtask

  initial begin
    X = 1'b0;
    Y = 1'b0;
    RST_N = 1'b0;
    #3;
    check_output("reset_initial", 1'b0);
    @(posedge CLK);
    #1;
    check_output("reset_held", 1'b0);
    #3 RST_N = 1'b1;

    // Async reset while in MATCH drops Z without a clock edge
    step(1'b1, 1'b0, "t1_arm", 1'b0);
    step(1'b0, 1'b1, "t1_match", 1'b1);
    #2 RST_N = 1'b0;
    #1;
    check_output("t1_async_reset", 1'b0);
    #2 RST_N = 1'b1;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, "t1_post_release", 1'b0);

    // Reset during ARMED aborts the pending sequence
    step(1'b1, 1'b0, "abort_arm", 1'b0);
    #2 RST_N = 1'b0;
    #2 RST_N = 1'b1;
    step(1'b0, 1'b1, "abort_y", 1'b0);
    step(1'b0, 1'b0, "abort_idle", 1'b0);

    // Simultaneous X and Y never match
    step(1'b1, 1'b1, "t2_xy_a", 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, "t2_idle", 1'b0);
    step(1'b1, 1'b1, "t2_xy_b", 1'b0);
    step(1'b0, 1'b1, "t2_y_after_xy", 1'b0);
    step(1'b0, 1'b0, "t2_idle_end", 1'b0);

    // Basic match, then a Y in MATCH is ignored
    step(1'b1, 1'b0, "t3_arm", 1'b0);
    step(1'b0, 1'b1, "t3_match", 1'b1);
    step(1'b0, 1'b0, "t3_after", 1'b0);
    step(1'b0, 1'b1, "t3_lone_y", 1'b0);
    step(1'b0, 1'b0, "t3_idle", 1'b0);

    // Y on the last edge of the window still matches
    step(1'b1, 1'b0, "t4a_arm", 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "t4a_wait", 1'b0);
    step(1'b0, 1'b1, "t4a_edge_k4", 1'b1);
    step(1'b0, 1'b0, "t4a_after", 1'b0);

    // Y one edge past the window does not
    step(1'b1, 1'b0, "t4b_arm", 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, "t4b_wait", 1'b0);
    step(1'b0, 1'b1, "t4b_edge_k5", 1'b0);
    step(1'b0, 1'b0, "t4b_after", 1'b0);

    // Re-arm at k+3 extends the window to k+7
    step(1'b1, 1'b0, "t5_arm_k", 1'b0);
    step(1'b0, 1'b0, "t5_k1", 1'b0);
    step(1'b0, 1'b0, "t5_k2", 1'b0);
    step(1'b1, 1'b0, "t5_rearm_k3", 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "t5_wait", 1'b0);
    step(1'b0, 1'b1, "t5_y_k7", 1'b1);
    step(1'b0, 1'b0, "t5_after", 1'b0);

    // X in MATCH re-arms directly; Y with X in ARMED still matches
    step(1'b1, 1'b0, "chain_arm", 1'b0);
    step(1'b0, 1'b1, "chain_match1", 1'b1);
    step(1'b1, 1'b0, "chain_rearm", 1'b0);
    step(1'b1, 1'b1, "chain_match2", 1'b1);
    step(1'b0, 1'b0, "chain_after", 1'b0);

    // Trailing lone X times out
    step(1'b1, 1'b0, "t6_arm", 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, "t6_idle", 1'b0);
    step(1'b0, 1'b1, "t6_late_y", 1'b0);
    step(1'b0, 1'b0, "t6_end", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
